// File: rtl/rr_encoder_8_3.sv
// Round-robin (or fixed-priority) 8:3 request encoder with a registered index under valid/ready, plus one-hot ack pulse.
// Latency 1 cycle from req_i to idx_o/ack_o; while idx_valid_o is held by !idx_ready_i no new grant is made.
module rr_encoder_8_3 #(
    parameter int         RR_EN    = 1,
    parameter logic [2:0] PTR_INIT = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] ack_o,
    output logic [2:0] idx_o,
    output logic       idx_valid_o,
    input  logic       idx_ready_i
);

    logic [2:0] r_ptr;
    logic [2:0] r_idx;
    logic       r_valid;
    logic [7:0] r_ack;

    logic [2:0] w_base;
    logic [2:0] w_winner;
    logic       w_hit;
    logic       w_load;

    // Search starts one past the last grant so the previous winner goes to the back of the line.
    always_comb begin
        w_base   = (RR_EN != 0) ? (r_ptr + 3'd1) : 3'd0;
        w_winner = 3'd0;
        w_hit    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!w_hit && req_i[w_base + 3'(k)]) begin
                w_hit    = 1'b1;
                w_winner = w_base + 3'(k);
            end
        end
    end

    assign w_load = (!r_valid || idx_ready_i) && (req_i != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= PTR_INIT;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_ack   <= 8'd0;
        end else begin
            r_ack <= 8'd0;
            if (w_load) begin
                r_idx   <= w_winner;
                r_valid <= 1'b1;
                r_ptr   <= w_winner;
                r_ack   <= 8'd1 << w_winner;
            end else if (r_valid && idx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ack_o       = r_ack;
    assign idx_o       = r_idx;
    assign idx_valid_o = r_valid;

endmodule

// File: doc/rr_encoder_8_3.md
Name: rr_encoder_8_3

Overview:
- Sequential round-robin encoder. Collapses 8 level-sensitive request lines into a stream of 3-bit indices under a valid/ready handshake.
- Sits upstream of the route-select decode in data_route. Each accepted index is later expanded back to one-hot downstream.
- Returns a one-cycle acknowledge pulse to the granted requester.
- Provides fairness across the 8 PE lanes when several request routing at once.

Parameters:
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority, lowest index wins.
- PTR_INIT, 7, reset value of the last-grant pointer. The default makes lane 0 highest priority after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  8  level request per lane. A lane holds its request until it sees its ack bit.
- ack_o  output  8  one-hot, one-cycle pulse marking the lane granted this cycle. Zero otherwise.
- idx_o  output  3  registered index of the granted lane.
- idx_valid_o  output  1  idx_o holds an unconsumed index.
- idx_ready_i  input  1  downstream accepts idx_o when high together with idx_valid_o.

Behaviour:
- Reset (async assert, sync release):
  - idx_o=0, idx_valid_o=0, ack_o=0, ptr=PTR_INIT.
  - Reset mid-operation drops any held index; no ack is reissued.
- Load condition: load = (!idx_valid_o | idx_ready_i) & (req_i != 0).
- Search order:
  - RR_EN=1: start at lane (ptr+1) mod 8 and proceed upward with wrap-around 7->0. The first set req_i bit wins.
  - RR_EN=0: lane 0 first, then upward.
- On load, at the rising edge:
  - idx_o <= winner, idx_valid_o <= 1, ptr <= winner.
  - ack_o is registered: the bit for the winner is high for exactly the cycle after the load edge, aligned with the first cycle idx_valid_o is high.
- Consume without reload (idx_valid_o & idx_ready_i & req_i==0): idx_valid_o <= 0; idx_o holds its last value.
- Stall (idx_valid_o & !idx_ready_i):
  - idx_o and idx_valid_o hold stable; ptr and ack_o are unchanged (ack_o=0).
  - No new grant is made, even if req_i changes.
- Back-to-back: with idx_ready_i held high and requests present, one grant per cycle. Throughput is 1 index/cycle.
- Requester rules:
  - A lane whose ack bit is high must deassert req_i in that same cycle, or it is considered a new request. That new request competes at the next load, fairly behind the other lanes.
  - The bench checks that the granted lane does not receive two consecutive grants while another lane is requesting.
- Latency: a request sampled at edge N appears on idx_o/idx_valid_o after edge N (1 cycle), provided the output register is free or draining.
- Boundary conditions:
  - req_i all-ones with ready high: grants rotate 0,1,...,7,0 from reset.
  - Single requester: granted every opportunity regardless of ptr.
  - ptr=7 wraps the search to lane 0.
  - Request arriving during a stall: it waits. It is not lost as long as the lane holds req_i.
- No combinational path from req_i or idx_ready_i to any output; all outputs are flop-driven.

Test Plan:
- Reset: assert rst_n=0 mid-stream with idx_valid_o=1 -> idx_valid_o=0, ack_o=0, idx_o=0 immediately. The next grant with req_i=8'hFF is idx 0.
- Rotation: RR_EN=1, req_i=8'hFF held, idx_ready_i=1 -> idx_o sequence 0,1,2,...,7,0 on consecutive cycles. ack_o sequence is 8'h01, 8'h02, ..., 8'h80, 8'h01.
- Wrap/skip: ptr=5 (last grant 5), req_i=8'b0000_1001 -> idx_o=0 next, then 3. ack_o=8'h01, then 8'h08. Each lane drops its req on ack.
- Stall: idx_valid_o=1, idx_o=2, idx_ready_i=0 for 4 cycles while req_i changes to 8'h40 -> idx_o stays 2, ack_o stays 0. On ready=1, idx_o becomes 6 the next cycle with ack_o=8'h40.
- Fixed priority: RR_EN=0, req_i=8'b1010_0100 held, ready=1 -> idx_o=2 repeatedly (starvation allowed). ack_o=8'h04 every cycle.
- Drain: single request lane 4, ready=1 -> idx_valid_o high for 1 cycle with idx_o=4, then low. idx_o holds 4 afterwards.
